data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Responder (target) side of a valid/ready load/store interface for the CPU data path.
- Word-indexed data storage with configurable wait states, so the core can be moved from its single-cycle combinational data memory to a handshaked, multi-cycle memory.
- Accepts one request at a time, performs the read or write, and returns a response with read data or an error flag.

Parameters:
- DEPTH, 64, number of 32-bit words stored; address is a word index.
- WAIT_CYCLES, 2, extra cycles between request accept and response; legal range 0..15.

Ports:
- clock  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  initiator presents a request
- req_ready  output  1  responder can accept a request this cycle
- req_we  input  1  1 = store (sw), 0 = load (lw)
- req_address  input  32  word index (ALU result)
- req_write_data  input  32  store data (rs2 value)
- resp_valid  output  1  response available
- resp_ready  input  1  initiator accepts the response
- resp_read_data  output  32  load data; 0 for stores and errors
- resp_error  output  1  address was out of range (req_address >= DEPTH)
- busy  output  1  high in any state other than IDLE

Behaviour:
- One clock (clock); reset is asynchronous and active-high (reset).
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - req_ready=1, resp_valid=0, resp_read_data=0, resp_error=0, busy=0.
  - Wait counter cleared; all memory words cleared to 0.
  - An in-flight store not yet committed is discarded.
- Request accept: a rising edge where req_valid=1 and req_ready=1 in IDLE. At that edge, req_we, req_address and req_write_data are latched. Later changes on the request inputs are ignored.
- States:
  - IDLE: req_ready=1.
    - On accept with WAIT_CYCLES=0, go to RESP.
    - On accept with WAIT_CYCLES>0, go to WAIT with count=WAIT_CYCLES-1.
  - WAIT: req_ready=0. Count decrements each edge; when count=0, the next edge moves to RESP.
  - RESP: req_ready=0, resp_valid=1. Outputs hold stable until resp_valid&resp_ready is sampled on an edge. That edge returns to IDLE, with resp_valid=0 and req_ready=1 afterwards.
- Latency:
  - With accept at edge E, resp_valid is high in the cycle following edge E+WAIT_CYCLES.
  - Minimum request-to-request spacing is WAIT_CYCLES+2 cycles when resp_ready is tied high.
  - A request is never accepted in the same cycle as a response handshake.
- Commit: on the edge entering RESP:
  - Store, in range: memory[address] <= write_data; resp_read_data=0; resp_error=0.
  - Load, in range: resp_read_data <= memory[address]; resp_error=0.
  - Out of range (either type): no memory change; resp_read_data=0; resp_error=1.
- Address compare uses the full 32 bits; no wrap-around or aliasing. Address DEPTH+k is an error for every k>=0.
- Back-pressure: resp_ready=0 holds RESP indefinitely, and memory stays unchanged after the commit.
- Load-after-store to the same address returns the stored value. The store commits before the load is even accepted.
- req_valid may be asserted while req_ready=0. The request is taken at the first edge in IDLE with req_valid still high.
- busy = (state != IDLE).
- memory is an unpacked array named memory, so the bench can read words hierarchically.

Test Plan:
- Reset check: assert reset mid-cycle, then release.
  -> req_ready=1, resp_valid=0, busy=0 immediately (asynchronous); memory[6]=0.
- Store then load, WAIT_CYCLES=2, resp_ready tied 1: sw addr=6, data=42, then lw addr=6.
  -> Each resp_valid rises 3 cycles after its accept edge.
  -> lw returns resp_read_data=42 with resp_error=0; memory[6]=42.
- WAIT_CYCLES=0: sw addr=3, data=0xDEADBEEF, then lw addr=3.
  -> resp_valid in the cycle right after each accept edge; lw returns 0xDEADBEEF.
- Out of range, DEPTH=64: sw addr=64, data=7, then lw addr=0xFFFFFFFF.
  -> Both responses have resp_error=1 and resp_read_data=0; no memory word changes.
- Back-pressure: lw addr=6 with resp_ready=0 for 5 cycles, then 1.
  -> resp_valid and resp_read_data=42 held stable throughout; req_ready=0 until the cycle after the handshake.
  -> A second request held on req_valid during that time is accepted only afterwards.
- Reset mid-operation: accept sw addr=10, data=99, then assert reset while in WAIT.
  -> FSM returns to IDLE, no response is produced, and memory[10]=0 after a subsequent lw addr=10.

Source files
------------

// File: rtl/data_memory_responder.sv
// Responder side of a valid/ready load/store port: word-indexed storage with
// a fixed number of wait states between request accept and response.
module data_memory_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_read_data,
  output logic        resp_error,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  count, count_next;
  logic        lat_we;
  logic [31:0] lat_address;
  logic [31:0] lat_write_data;
  logic [31:0] memory [DEPTH];

  logic        accept;
  logic        enter_resp;
  logic        in_range;
  logic        commit_we;
  logic [31:0] commit_address;
  logic [31:0] commit_data;
  logic [AW-1:0] index;

  assign accept     = req_valid && (state == IDLE);
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  // With zero wait states the commit happens on the accept edge itself, so
  // the live request inputs are used; otherwise the latched copy is used.
  always_comb begin
    commit_we      = lat_we;
    commit_address = lat_address;
    commit_data    = lat_write_data;
    if (state == IDLE) begin
      commit_we      = req_we;
      commit_address = req_address;
      commit_data    = req_write_data;
    end
  end

  assign enter_resp = (state != RESP) && (state_next == RESP);
  assign in_range   = commit_address < 32'(DEPTH);
  assign index      = commit_address[AW-1:0];

  // Next-state and wait-counter logic
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            count_next = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (count == '0) state_next = RESP;
        else             count_next = count - 4'd1;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counter, request latch and response registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      lat_we         <= 1'b0;
      lat_address    <= '0;
      lat_write_data <= '0;
      resp_read_data <= '0;
      resp_error     <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (accept) begin
        lat_we         <= req_we;
        lat_address    <= req_address;
        lat_write_data <= req_write_data;
      end
      if (enter_resp) begin
        if (!in_range) begin
          resp_read_data <= '0;
          resp_error     <= 1'b1;
        end else if (commit_we) begin
          resp_read_data <= '0;
          resp_error     <= 1'b0;
        end else begin
          resp_read_data <= memory[index];
          resp_error     <= 1'b0;
        end
      end
    end
  end

  // Storage array: cleared on reset, written only on the edge entering RESP
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) memory[i] <= '0;
    end else if (enter_resp && in_range && commit_we) begin
      memory[index] <= commit_data;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: instance 0 has two wait states, instance 1 has none.
module tb_data_memory_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid      [2];
  logic        req_we         [2];
  logic [31:0] req_address    [2];
  logic [31:0] req_write_data [2];
  logic        resp_ready     [2];
  logic        req_ready      [2];
  logic        resp_valid     [2];
  logic [31:0] resp_read_data [2];
  logic        resp_error     [2];
  logic        busy           [2];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  data_memory_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_w2 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_address(req_address[0]), .req_write_data(req_write_data[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_read_data(resp_read_data[0]), .resp_error(resp_error[0]), .busy(busy[0])
  );

  data_memory_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_w0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_address(req_address[1]), .req_write_data(req_write_data[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_read_data(resp_read_data[1]), .resp_error(resp_error[1]), .busy(busy[1])
  );

  // Present a request at a negedge, let the next posedge accept it, then drop valid.
  task automatic issue(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clock);
    req_valid[d] = 1'b1;
    req_we[d] = we;
    req_address[d] = a;
    req_write_data[d] = wd;
    @(posedge clock);
    #1;
    req_valid[d] = 1'b0;
  endtask

  // Count negedges until resp_valid is seen (bounded); capture response there.
  task automatic wait_resp(input int d, output int lat, output logic ok,
                           output logic [31:0] rd, output logic er);
    lat = 0; ok = 1'b0; rd = '0; er = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      lat++;
      if (resp_valid[d]) begin
        ok = 1'b1; rd = resp_read_data[d]; er = resp_error[d];
        break;
      end
    end
  endtask

  // Full transaction with resp_ready high: response handshakes at next posedge.
  task automatic transact(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic ok, output logic [31:0] rd, output logic er);
    issue(d, we, a, wd);
    wait_resp(d, lat, ok, rd, er);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clock);
    reset = 1'b0;
    issue(0, 1'b1, 32'd6, 32'd5);
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL reset_pre_busy got=%0b exp=1", busy[0]); end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready[0]); end
    checks++;
    if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%0b exp=0", resp_valid[0]); end
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy[0]); end
    checks++;
    if (resp_read_data[0] !== 32'd0 || resp_error[0] !== 1'b0) begin
      errors++; $display("FAIL reset_resp got=%h/%0b exp=0/0", resp_read_data[0], resp_error[0]);
    end
    checks++;
    if (u_w2.memory[6] !== 32'd0) begin errors++; $display("FAIL reset_mem6 got=%h exp=0", u_w2.memory[6]); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (req_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL reset_release got ready=%0b busy=%0b exp 1/0", req_ready[0], busy[0]);
    end
  endtask

  task automatic test_store_load;
    int lat; logic ok; logic [31:0] rd; logic er;
    transact(0, 1'b1, 32'd6, 32'd42, lat, ok, rd, er);
    checks++;
    if (!ok || lat != 3) begin errors++; $display("FAIL sw_latency got=%0d ok=%0b exp=3", lat, ok); end
    checks++;
    if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL sw_resp got=%h/%0b exp=0/0", rd, er); end
    transact(0, 1'b0, 32'd6, 32'd0, lat, ok, rd, er);
    checks++;
    if (!ok || lat != 3) begin errors++; $display("FAIL lw_latency got=%0d ok=%0b exp=3", lat, ok); end
    checks++;
    if (rd !== 32'd42 || er !== 1'b0) begin errors++; $display("FAIL lw_data got=%h/%0b exp=2a/0", rd, er); end
    checks++;
    if (u_w2.memory[6] !== 32'd42) begin errors++; $display("FAIL mem6 got=%h exp=2a", u_w2.memory[6]); end
  endtask

  task automatic test_wait0;
    int lat; logic ok; logic [31:0] rd; logic er;
    transact(1, 1'b1, 32'd3, 32'hDEADBEEF, lat, ok, rd, er);
    checks++;
    if (!ok || lat != 1) begin errors++; $display("FAIL w0_sw_latency got=%0d ok=%0b exp=1", lat, ok); end
    transact(1, 1'b0, 32'd3, 32'd0, lat, ok, rd, er);
    checks++;
    if (!ok || lat != 1) begin errors++; $display("FAIL w0_lw_latency got=%0d ok=%0b exp=1", lat, ok); end
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL w0_lw_data got=%h/%0b exp=deadbeef/0", rd, er); end
  endtask

  task automatic test_out_of_range;
    int lat; logic ok; logic [31:0] rd; logic er;
    transact(0, 1'b1, 32'd64, 32'd7, lat, ok, rd, er);
    checks++;
    if (!ok || rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL oor_sw got=%h/%0b ok=%0b exp=0/1", rd, er, ok); end
    transact(0, 1'b0, 32'hFFFFFFFF, 32'd0, lat, ok, rd, er);
    checks++;
    if (!ok || rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL oor_lw got=%h/%0b ok=%0b exp=0/1", rd, er, ok); end
    transact(0, 1'b0, 32'd63, 32'd0, lat, ok, rd, er);
    checks++;
    if (!ok || rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL edge63_lw got=%h/%0b ok=%0b exp=0/0", rd, er, ok); end
    checks++;
    if (u_w2.memory[0] !== 32'd0) begin errors++; $display("FAIL oor_mem0 got=%h exp=0", u_w2.memory[0]); end
    checks++;
    if (u_w2.memory[63] !== 32'd0) begin errors++; $display("FAIL oor_mem63 got=%h exp=0", u_w2.memory[63]); end
    checks++;
    if (u_w2.memory[6] !== 32'd42) begin errors++; $display("FAIL oor_mem6 got=%h exp=2a", u_w2.memory[6]); end
  endtask

  task automatic test_back_pressure;
    int lat; logic ok; logic [31:0] rd; logic er;
    resp_ready[0] = 1'b0;
    issue(0, 1'b0, 32'd6, 32'd0);
    // Second request held pending while the first is outstanding.
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_address[0] = 32'd20; req_write_data[0] = 32'h55;
    wait_resp(0, lat, ok, rd, er);
    checks++;
    if (!ok || rd !== 32'd42 || er !== 1'b0) begin errors++; $display("FAIL bp_first got=%h/%0b ok=%0b exp=2a/0", rd, er, ok); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checks++;
      if (resp_valid[0] !== 1'b1 || resp_read_data[0] !== 32'd42 || req_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got valid=%0b data=%h ready=%0b exp 1/2a/0", k, resp_valid[0], resp_read_data[0], req_ready[0]);
      end
    end
    checks++;
    if (u_w2.memory[20] !== 32'd0) begin errors++; $display("FAIL bp_early_commit got=%h exp=0", u_w2.memory[20]); end
    resp_ready[0] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
      errors++; $display("FAIL bp_after_hs got ready=%0b valid=%0b exp 1/0", req_ready[0], resp_valid[0]);
    end
    @(posedge clock);
    #1;
    req_valid[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL bp_second_accept got busy=%0b exp=1", busy[0]); end
    wait_resp(0, lat, ok, rd, er);
    @(posedge clock);
    #1;
    checks++;
    if (!ok || lat != 3 || er !== 1'b0) begin errors++; $display("FAIL bp_second_resp got lat=%0d err=%0b ok=%0b exp 3/0", lat, er, ok); end
    checks++;
    if (u_w2.memory[20] !== 32'h55) begin errors++; $display("FAIL bp_mem20 got=%h exp=55", u_w2.memory[20]); end
  endtask

  task automatic test_reset_mid;
    int lat; logic ok; logic [31:0] rd; logic er;
    issue(0, 1'b1, 32'd10, 32'd99);
    #3 reset = 1'b1;
    #1;
    checks++;
    if (busy[0] !== 1'b0 || resp_valid[0] !== 1'b0) begin
      errors++; $display("FAIL mid_reset got busy=%0b valid=%0b exp 0/0", busy[0], resp_valid[0]);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++;
      if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL mid_no_resp[%0d] got=%0b exp=0", k, resp_valid[0]); end
    end
    transact(0, 1'b0, 32'd10, 32'd0, lat, ok, rd, er);
    checks++;
    if (!ok || rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL mid_lw10 got=%h/%0b ok=%0b exp=0/0", rd, er, ok); end
    checks++;
    if (u_w2.memory[6] !== 32'd0) begin errors++; $display("FAIL mid_mem6_cleared got=%h exp=0", u_w2.memory[6]); end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_address[d] = '0;
      req_write_data[d] = '0; resp_ready[d] = 1'b1;
    end
    test_reset;
    test_store_load;
    test_wait0;
    test_out_of_range;
    test_back_pressure;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
